rshift_multicycle: RTL and testbench



---
 rtl/rshift_multicycle.sv | 73 +++++++
 tb/tb_rshift_multicycle.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rshift_multicycle.sv
// rshift_multicycle: iterative log-stage right shifter (logical/arithmetic) with start/ready handshake.
// Optional build macro RSHIFT_EARLY_DONE_EN: finish as soon as the remaining amount bits are all zero.
module rshift_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic               ctrl_arith,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [WIDTH-1:0]   data_operandA,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);
    localparam int IDX_W = SHAMT_W > 1 ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   work, stage_val;
    logic [SHAMT_W-1:0] amt, step;
    logic [IDX_W-1:0]   idx;
    logic               arith, accept, last, skip_all;

    assign step = SHAMT_W'(1) << idx;
    assign stage_val = amt[idx] ? (arith ? WIDTH'($signed(work) >>> step) : work >> step) : work;
`ifdef RSHIFT_EARLY_DONE_EN
    assign last     = (idx == '0) || ((amt & (step - SHAMT_W'(1))) == '0);
    assign skip_all = ctrl_shiftamt == '0;
`else
    assign last     = idx == '0;
    assign skip_all = 1'b0;
`endif
    assign busy           = state == SHIFT;
    assign data_resultRDY = state == DONE;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: a start is taken in IDLE or DONE, never while shifting
    always_comb begin
        accept    = ctrl_start && state != SHIFT;
        state_nxt = IDLE;
        if (accept)              state_nxt = skip_all ? DONE : SHIFT;
        else if (state == SHIFT) state_nxt = last ? DONE : SHIFT;
    end

    // Datapath: latch the request, then apply one power-of-two stage per clock, MSB stage first
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work        <= '0;
            amt         <= '0;
            arith       <= 1'b0;
            idx         <= '0;
            data_result <= '0;
        end else if (accept) begin
            work  <= data_operandA;
            amt   <= ctrl_shiftamt;
            arith <= ctrl_arith;
            idx   <= IDX_W'(SHAMT_W - 1);
            if (skip_all) data_result <= data_operandA;
        end else if (state == SHIFT) begin
            work <= stage_val;
            if (last) data_result <= stage_val;
            else      idx <= idx - IDX_W'(1);
        end
    end
endmodule

// File: tb/tb_rshift_multicycle.sv
// tb_rshift_multicycle: scoreboard bench; driver pushes expected results/timing, monitor checks every cycle.
module tb_rshift_multicycle;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
`ifdef RSHIFT_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               ctrl_start = 1'b0;
    logic               ctrl_arith = 1'b0;
    logic [SHAMT_W-1:0] ctrl_shiftamt = '0;
    logic [WIDTH-1:0]   data_operandA = '0;
    logic [WIDTH-1:0]   data_result;
    logic               data_resultRDY;
    logic               busy;

    rshift_multicycle #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock(clock), .reset(reset), .ctrl_start(ctrl_start), .ctrl_arith(ctrl_arith),
        .ctrl_shiftamt(ctrl_shiftamt), .data_operandA(data_operandA),
        .data_result(data_result), .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               start;
        int               due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic exp_rdy, exp_busy;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    // Reference: bit i of the result is bit i+s of A, or the fill bit past the top
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [SHAMT_W-1:0] s, input logic ar);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++)
            r[i] = (i + int'(s) < WIDTH) ? a[i + int'(s)] : (ar & a[WIDTH-1]);
        return r;
    endfunction

    // Clock edges from the start edge to the edge that completes the op
    function automatic int lat(input logic [SHAMT_W-1:0] s);
        int tz;
        tz = 0;
        while (tz < SHAMT_W && !s[tz]) tz++;
        return EARLY ? SHAMT_W - tz : SHAMT_W;
    endfunction

    task automatic push(input logic [WIDTH-1:0] a, input logic [SHAMT_W-1:0] s, input logic ar);
        exp_t e;
        e.res   = model(a, s, ar);
        e.start = cyc + 1;
        e.due   = e.start + lat(s);
        q.push_back(e);
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic [SHAMT_W-1:0] s, input logic ar);
        data_operandA = a;
        ctrl_shiftamt = s;
        ctrl_arith    = ar;
        ctrl_start    = 1'b1;
        push(a, s, ar);
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [SHAMT_W-1:0] s, input logic ar);
        @(negedge clock);
        drive(a, s, ar);
        @(negedge clock);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            #1;
            if (q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout waiting for RDY, %0d results outstanding", q.size());
        q.delete();
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (data_resultRDY) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout waiting for RDY in back-to-back run");
    endtask

    // Hold start high; each new operand is presented in the DONE cycle of the previous op
    task automatic b2b(input int n);
        @(negedge clock);
        drive(32'h8000_0000 | $urandom, 5'($urandom), 1'($urandom));
        for (int i = 1; i < n; i++) begin
            wait_rdy();
            drive(i % 2 ? ($urandom & 32'h7FFF_FFFF) : ($urandom | 32'h8000_0000), 5'($urandom), 1'($urandom));
        end
        wait_rdy();
        ctrl_start = 1'b0;
        wait_done();
    endtask

    // Monitor: every cycle, RDY and busy must match the scoreboard front; on RDY, result must match
    always @(negedge clock) begin
        if (!reset) begin
            exp_rdy  = q.size() > 0 && q[0].due == cyc;
            exp_busy = q.size() > 0 && cyc >= q[0].start && cyc < q[0].due;
            check("rdy", WIDTH'(data_resultRDY), WIDTH'(exp_rdy));
            check("busy", WIDTH'(busy), WIDTH'(exp_busy));
            if (data_resultRDY && exp_rdy) begin
                check("result", data_result, q[0].res);
                void'(q.pop_front());
            end else if (q.size() > 0 && cyc >= q[0].due) begin
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #3;
        check("reset_result", data_result, '0);
        check("reset_rdy", WIDTH'(data_resultRDY), '0);
        check("reset_busy", WIDTH'(busy), '0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        issue(32'h8000_0000, 5'd16, 1'b0); wait_done();
        issue(32'h8000_0000, 5'd31, 1'b1); wait_done();
        issue(32'h8000_0000, 5'd31, 1'b0); wait_done();
        issue(32'h7FFF_FFFF, 5'd4,  1'b1); wait_done();
        issue(32'hDEAD_BEEF, 5'd0,  1'b1); wait_done();
        issue(32'hDEAD_BEEF, 5'd1,  1'b0); wait_done();
        issue(32'hC000_0001, 5'd1,  1'b1); wait_done();

        // Inputs change right after the start edge; the latched copies must be used
        issue(32'h1234_5678, 5'd8, 1'b0);
        data_operandA = 32'hFFFF_FFFF;
        ctrl_shiftamt = 5'd0;
        ctrl_arith    = 1'b1;
        wait_done();

        // A start pulse while busy must be ignored entirely
        issue(32'h8765_4321, 5'd1, 1'b1);
        @(negedge clock);
        data_operandA = 32'h0F0F_0F0F;
        ctrl_shiftamt = 5'd3;
        ctrl_start    = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        wait_done();
        repeat (8) @(negedge clock);

        b2b(4);

        // Asynchronous reset mid-operation discards the op immediately
        issue(32'hF000_0000, 5'd5, 1'b1);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        check("midreset_result", data_result, '0);
        check("midreset_rdy", WIDTH'(data_resultRDY), '0);
        check("midreset_busy", WIDTH'(busy), '0);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        issue(32'hF000_0000, 5'd5, 1'b1); wait_done();

        for (int i = 0; i < 40; i++) begin
            issue($urandom, 5'($urandom), 1'($urandom));
            wait_done();
        end
        for (int i = 0; i < 4; i++) b2b(3);

        repeat (4) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
